// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, defaults and the baud-divisor clamp.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_WAIT_IDLE
  } uart_state_e;

  localparam int DEFAULT_K = 109;
  localparam int MIN_DLEN  = 5;

  // A divisor below 2 would leave no room for a half-bit start check.
  function automatic logic [31:0] k_eff_clamp(input logic [31:0] k);
    return (k < 32'd2) ? 32'd2 : k;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter shared by the UART engines: counts up to a half or full bit and flags btu.
module uart_bit_timer #(
  parameter int KW = 19
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  input  logic          clr_i,
  input  logic          half_i,
  input  logic [KW-1:0] k_eff_i,
  output logic          btu_o
);

  logic [KW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] target;

  always_comb begin
    target = half_i ? (k_eff_i >> 1) : (k_eff_i - KW'(1));
    btu_o  = run_i && (cnt_q == target);
    cnt_d  = cnt_q + KW'(1);
    if (!run_i || clr_i || btu_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_engine_gen.sv
// Parametrised UART receiver: synchronised rx, 5..MAXD data bits, optional parity, 1/2 stop bits,
// false-start rejection and framing/parity/break flags held from one frame end to the next.
module uart_rx_engine_gen
  import uart_pkg::*;
#(
  parameter int KW   = 19,
  parameter int MAXD = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic [KW-1:0]   k,
  input  logic [3:0]      dlen,
  input  logic            p_en,
  input  logic            p_odd,
  input  logic            two_stop,
  output logic            start,
  output logic            btu,
  output logic            busy,
  output logic            done,
  output logic [MAXD-1:0] rx_data,
  output logic            perr,
  output logic            ferr,
  output logic            brk
);

  localparam logic [3:0] DMIN = 4'(MIN_DLEN);
  localparam logic [3:0] DMAX = 4'(MAXD);

  logic            rx_m_q, rx_s_q;
  uart_state_e     state_q, state_d;
  logic [KW-1:0]   keff_q, keff_d, keff_c;
  logic [3:0]      dlen_q, dlen_d, dlen_c;
  logic            p_en_q, p_en_d, p_odd_q, p_odd_d, two_stop_q, two_stop_d;
  logic [MAXD-1:0] shift_q, shift_d;
  logic [3:0]      idx_q, idx_d;
  logic            par_q, par_d;
  logic            zero_q, zero_d;
  logic            s1bad_q, s1bad_d;
  logic            start_q, start_d, done_q, done_d;
  logic [MAXD-1:0] data_q, data_d;
  logic            perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic            btu_w, frame_end, ferr_n, brk_n;

  uart_bit_timer #(.KW(KW)) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .run_i   (state_q != S_IDLE),
    .clr_i   (state_d != state_q),
    .half_i  (state_q == S_START),
    .k_eff_i (keff_q),
    .btu_o   (btu_w)
  );

  always_comb begin
    state_d    = state_q;
    keff_d     = keff_q;
    dlen_d     = dlen_q;
    p_en_d     = p_en_q;
    p_odd_d    = p_odd_q;
    two_stop_d = two_stop_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    par_d      = par_q;
    zero_d     = zero_q;
    s1bad_d    = s1bad_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    frame_end  = 1'b0;
    ferr_n     = 1'b0;
    brk_n      = 1'b0;

    keff_c = KW'(k_eff_clamp(32'(k)));
    dlen_c = dlen;
    if (dlen < DMIN)      dlen_c = DMIN;
    else if (dlen > DMAX) dlen_c = DMAX;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d    = S_START;
          start_d    = 1'b1;
          keff_d     = keff_c;
          dlen_d     = dlen_c;
          p_en_d     = p_en;
          p_odd_d    = p_odd;
          two_stop_d = two_stop;
          shift_d    = '0;
          idx_d      = '0;
          par_d      = 1'b0;
          zero_d     = 1'b1;
          s1bad_d    = 1'b0;
        end
      end
      S_START: begin
        if (btu_w) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (btu_w) begin
          for (int i = 0; i < MAXD; i++) begin
            if (idx_q == 4'(i)) shift_d[i] = rx_s_q;
          end
          zero_d = zero_q & ~rx_s_q;
          if (idx_q == dlen_q - 4'd1) state_d = p_en_q ? S_PARITY : S_STOP1;
          else                        idx_d   = idx_q + 4'd1;
        end
      end
      S_PARITY: begin
        if (btu_w) begin
          par_d   = rx_s_q;
          zero_d  = zero_q & ~rx_s_q;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (btu_w) begin
          if (two_stop_q) begin
            s1bad_d = ~rx_s_q;
            state_d = S_STOP2;
          end else begin
            frame_end = 1'b1;
            ferr_n    = ~rx_s_q;
            brk_n     = zero_q & ~rx_s_q;
          end
        end
      end
      S_STOP2: begin
        if (btu_w) begin
          frame_end = 1'b1;
          ferr_n    = s1bad_q | ~rx_s_q;
          brk_n     = zero_q & s1bad_q;
        end
      end
      S_WAIT_IDLE: begin
        // Hold off re-arming until the line has returned high, so a break yields one frame.
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_end) begin
      done_d  = 1'b1;
      data_d  = shift_q;
      perr_d  = p_en_q & ((^shift_q ^ par_q) != p_odd_q);
      ferr_d  = ferr_n;
      brk_d   = brk_n;
      state_d = ferr_n ? S_WAIT_IDLE : S_IDLE;
    end
  end

  // ---- control and output registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= S_IDLE;
      keff_q  <= KW'(DEFAULT_K);
      start_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      state_q <= state_d;
      keff_q  <= keff_d;
      start_q <= start_d;
      done_q  <= done_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  // ---- frame datapath, initialised on every accepted start edge ----
  always_ff @(posedge clk) begin
    dlen_q     <= dlen_d;
    p_en_q     <= p_en_d;
    p_odd_q    <= p_odd_d;
    two_stop_q <= two_stop_d;
    shift_q    <= shift_d;
    idx_q      <= idx_d;
    par_q      <= par_d;
    zero_q     <= zero_d;
    s1bad_q    <= s1bad_d;
  end

  assign start   = start_q;
  assign btu     = btu_w;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign rx_data = data_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign brk     = brk_q;

endmodule

// File: tb/tb_uart_rx_engine_gen.sv
// Directed bench for uart_rx_engine_gen: frames pushed to a scoreboard, a monitor checks each done.
module tb_uart_rx_engine_gen;

  localparam int KW   = 19;
  localparam int MAXD = 9;
  localparam int KB   = 109;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx  = 1'b1;
  logic [KW-1:0]   k   = KW'(KB);
  logic [3:0]      dlen = 4'd8;
  logic            p_en = 1'b0, p_odd = 1'b0, two_stop = 1'b0;
  logic            start, btu, busy, done, perr, ferr, brk;
  logic [MAXD-1:0] rx_data;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, n_start = 0;
  int   e_tm, s0;

  uart_rx_engine_gen #(.KW(KW), .MAXD(MAXD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .k(k), .dlen(dlen), .p_en(p_en), .p_odd(p_odd),
    .two_stop(two_stop), .start(start), .btu(btu), .busy(busy), .done(done),
    .rx_data(rx_data), .perr(perr), .ferr(ferr), .brk(brk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitor: every done pops one expected frame.
  always @(negedge clk) begin
    exp_t ex;
    if (start) n_start++;
    if (done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, required no pending frame");
      end else begin
        ex = sb.pop_front();
        chk("rx_data", 32'(rx_data), 32'(ex.data));
        chk("perr", 32'(perr), 32'(ex.perr));
        chk("ferr", 32'(ferr), 32'(ex.ferr));
        chk("brk", 32'(brk), 32'(ex.brk));
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (KB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input logic hp, input logic pb,
                            input logic s1, input logic hs2, input logic s2);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (hp) send_bit(pb);
    send_bit(s1);
    if (hs2) send_bit(s2);
  endtask

  task automatic cfg(input logic [3:0] dl, input logic pe, input logic po, input logic ts);
    dlen = dl; p_en = pe; p_odd = po; two_stop = ts;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({start, btu, busy, done, perr, ferr, brk, rx_data}), 32'd0);
    rst = 1'b0;
    idle(10);

    // 8N1 0xA5 with start/btu/done timing relative to edge 0
    cfg(4'd8, 1'b0, 1'b0, 1'b0);
    sb.push_back('{9'h0A5, 1'b0, 1'b0, 1'b0});
    fork
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("start_after_e1", 32'(start), 32'd0);
        @(negedge clk);
        chk("start_after_e2", 32'(start), 32'd1);
        e_tm = 2;
        while (!btu && e_tm < 300) begin @(negedge clk); e_tm++; end
        chk("start_btu_edge", 32'(e_tm), 32'd56);
        while (!done && e_tm < 1300) begin @(negedge clk); e_tm++; end
        n_cmp++;
        if (e_tm < 1038 || e_tm > 1047) begin
          n_bad++;
          $display("FAIL done_edge: got %0d, required 1038..1047", e_tm);
        end
      end
    join
    idle(20);

    // 7E1 0x41, good then bad parity
    cfg(4'd7, 1'b1, 1'b0, 1'b0);
    sb.push_back('{9'h041, 1'b0, 1'b0, 1'b0});
    send_frame(9'h041, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    sb.push_back('{9'h041, 1'b1, 1'b0, 1'b0});
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);

    // 9O2 0x1FF, clean then second stop low
    cfg(4'd9, 1'b1, 1'b1, 1'b1);
    sb.push_back('{9'h1FF, 1'b0, 1'b0, 1'b0});
    send_frame(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(20);
    sb.push_back('{9'h1FF, 1'b0, 1'b1, 1'b0});
    s0 = n_start;
    send_frame(9'h1FF, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    chk("stop2_done_seen", 32'(sb.size()), 32'd0);
    chk("wait_idle_busy", 32'(busy), 32'd1);
    chk("wait_idle_no_restart", 32'(n_start - s0), 32'd1);
    idle(5);
    chk("wait_idle_exit", 32'(busy), 32'd0);

    // false start: 30 low cycles
    cfg(4'd8, 1'b0, 1'b0, 1'b0);
    s0 = n_start;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    chk("false_start_busy_hi", 32'(busy), 32'd1);
    idle(100);
    chk("false_start_pulse", 32'(n_start - s0), 32'd1);
    chk("false_start_busy_lo", 32'(busy), 32'd0);

    // reset in the middle of DATA; flags still hold the 9O2 stop2 frame
    rx = 1'b0;
    repeat (250) @(negedge clk);
    chk("mid_data_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", 32'({start, btu, busy, done, perr, ferr, brk, rx_data}), 32'd0);
    rst = 1'b0;
    idle(20);
    sb.push_back('{9'h05A, 1'b0, 1'b0, 1'b0});
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);

    // break: line low for 3000 cycles
    sb.push_back('{9'h000, 1'b0, 1'b1, 1'b1});
    s0 = n_start;
    rx = 1'b0;
    repeat (3000) @(negedge clk);
    chk("break_one_start", 32'(n_start - s0), 32'd1);
    chk("break_busy_hold", 32'(busy), 32'd1);
    idle(10);
    chk("break_release", 32'(busy), 32'd0);
    chk("break_no_restart", 32'(n_start - s0), 32'd1);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("break_restart_after_high", 32'(n_start - s0), 32'd2);
    idle(100);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
